// File: rtl/playlist_pkg.sv
// Shared encodings for the playlist sequencer: FSM states, repeat/shuffle
// modes and the shuffle LFSR seed/taps.
package playlist_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    PAUSED  = 2'd1,
    PLAYING = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ALL  = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;
  localparam logic [1:0] MODE_SHUF = 2'b11;

  // x^8 + x^6 + x^5 + x^4 + 1, maximal length, so a non-zero seed never reaches zero
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/shuffle_lfsr.sv
// Free-running 8-bit Fibonacci LFSR that feeds shuffle song selection.
module shuffle_lfsr
  import playlist_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) q <= LFSR_SEED;
    else        q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/playlist_ctrl.sv
// Playback sequencer: play/pause FSM, timed inter-song gap, prev restart-or-back
// and repeat-off/all/one/shuffle song selection driving the player.
module playlist_ctrl
  import playlist_pkg::*;
#(
  parameter int NUM_SONGS   = 4,
  parameter int SONG_W      = 2,
  parameter int GAP_CYCLES  = 16,
  parameter int PREV_WINDOW = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic [1:0]        mode,
  input  logic              song_done,
  output logic              play,
  output logic [SONG_W-1:0] song,
  output logic              reset_player,
  output logic [1:0]        state
);

  localparam int EL_W = $clog2(PREV_WINDOW + 1);
  localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [GC_W-1:0]   GAP_LOAD  = (GAP_CYCLES > 0) ? GC_W'(GAP_CYCLES - 1) : '0;

  state_t             state_q, state_d;
  logic [SONG_W-1:0]  song_q, song_d;
  logic [SONG_W-1:0]  pending_q, pending_d;
  logic [GC_W-1:0]    gap_q, gap_d;
  logic [EL_W-1:0]    elapsed_q, elapsed_d;
  logic               autoplay_q, autoplay_d;
  logic               play_q, reset_player_q;
  logic [7:0]         lfsr_q;
  logic [SONG_W-1:0]  shuffle_pick;
  logic [SONG_W-1:0]  new_pending;
  logic               unused_lfsr_bits;

  function automatic logic [SONG_W-1:0] inc(input logic [SONG_W-1:0] s);
    return (s == LAST_SONG) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [SONG_W-1:0] dec(input logic [SONG_W-1:0] s);
    return (s == '0) ? LAST_SONG : s - 1'b1;
  endfunction

  shuffle_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign unused_lfsr_bits = &lfsr_q;

  // Fold the raw LFSR bits into range, then step past the current song so
  // shuffle never repeats the track that just ended.
  always_comb begin
    shuffle_pick = lfsr_q[SONG_W-1:0];
    if (int'(shuffle_pick) >= NUM_SONGS) shuffle_pick = shuffle_pick - SONG_W'(NUM_SONGS);
    if (shuffle_pick == song_q) shuffle_pick = inc(song_q);
  end

  always_comb begin
    case (mode)
      MODE_ONE:  new_pending = song_q;
      MODE_SHUF: new_pending = shuffle_pick;
      default:   new_pending = inc(song_q);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    pending_d  = pending_q;
    gap_d      = gap_q;
    elapsed_d  = elapsed_q;
    autoplay_d = autoplay_q;

    case (state_q)
      LOAD: begin
        elapsed_d = '0;
        state_d   = autoplay_q ? PLAYING : PAUSED;
      end

      PAUSED: begin
        if (play_button) begin
          state_d = PLAYING;
        end else if (next_button) begin
          song_d = inc(song_q); state_d = LOAD; autoplay_d = 1'b0;
        end else if (prev_button) begin
          song_d = dec(song_q); state_d = LOAD; autoplay_d = 1'b0;
        end
      end

      PLAYING: begin
        if (int'(elapsed_q) < PREV_WINDOW) elapsed_d = elapsed_q + 1'b1;
        if (play_button) begin
          state_d = PAUSED;
        end else if (next_button) begin
          song_d = inc(song_q); state_d = LOAD; autoplay_d = 1'b1;
        end else if (prev_button) begin
          // Early in the song prev steps back; later it restarts the same song.
          if (int'(elapsed_q) < PREV_WINDOW) song_d = dec(song_q);
          state_d = LOAD; autoplay_d = 1'b1;
        end else if (song_done) begin
          if (mode == MODE_OFF && song_q == LAST_SONG) begin
            song_d = '0; state_d = LOAD; autoplay_d = 1'b0;
          end else if (GAP_CYCLES > 0) begin
            pending_d = new_pending; gap_d = GAP_LOAD; state_d = GAP;
          end else begin
            song_d = new_pending; state_d = LOAD; autoplay_d = 1'b1;
          end
        end
      end

      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == '0) begin
          song_d = pending_q; state_d = LOAD; autoplay_d = 1'b1;
        end else if (play_button) begin
          song_d = pending_q; state_d = LOAD; autoplay_d = 1'b0;
        end else if (next_button) begin
          song_d = inc(song_q); state_d = LOAD; autoplay_d = 1'b1;
        end else if (prev_button) begin
          song_d = dec(song_q); state_d = LOAD; autoplay_d = 1'b1;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= LOAD;
      song_q         <= '0;
      pending_q      <= '0;
      gap_q          <= '0;
      elapsed_q      <= '0;
      autoplay_q     <= 1'b0;
      play_q         <= 1'b0;
      reset_player_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      song_q         <= song_d;
      pending_q      <= pending_d;
      gap_q          <= gap_d;
      elapsed_q      <= elapsed_d;
      autoplay_q     <= autoplay_d;
      // Player controls are registered from the next state so they line up with it.
      play_q         <= (state_d == PLAYING);
      reset_player_q <= (state_d == LOAD);
    end
  end

  assign play         = play_q;
  assign song         = song_q;
  assign reset_player = reset_player_q;
  assign state        = state_q;

endmodule

// File: doc/playlist_ctrl.md
Name: playlist_ctrl

Overview:
Playback sequencer for the music player. It drives the player's play / song / reset_player inputs from debounced one-pulse buttons (play, next, prev), a repeat/shuffle mode select and the player's song_done. It adds a pause/resume FSM, a timed inter-song gap, "prev" restart-vs-back behaviour, and repeat-off/all/one/shuffle song selection.

Parameters:
NUM_SONGS, 4, number of songs; legal range 2^(SONG_W-1) < NUM_SONGS <= 2^SONG_W
SONG_W, 2, width of the song index
GAP_CYCLES, 16, silent cycles between auto-advanced songs; 0 means no gap
PREV_WINDOW, 64, play cycles after song start within which prev goes to the previous song

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset; sampled on rising clk, 0 = reset
play_button  in  1  one-cycle pulse: toggle play/pause
next_button  in  1  one-cycle pulse: skip forward
prev_button  in  1  one-cycle pulse: restart current song or go back
mode  in  2  00 repeat-off, 01 repeat-all, 10 repeat-one, 11 shuffle
song_done  in  1  player reports end of current song
play  out  1  player enable; registered
song  out  SONG_W  current song index; registered
reset_player  out  1  one-cycle player reset on song load; registered
state  out  2  FSM state, for display/debug

Behaviour:
- Reset (reset==0 at clk edge): state=LOAD, song=0, play=0, reset_player=1, autoplay=0, gap counter=0, elapsed=0, LFSR=8'h01. The first cycle after release is LOAD; the next is PAUSED.
- States: LOAD, PAUSED, PLAYING, GAP. In LOAD, reset_player=1 and play=0. PLAYING is the only state with play=1. reset_player=0 everywhere except LOAD.
- Event priority in one cycle: play_button > next_button > prev_button > song_done. Lower-priority events in the same cycle are dropped.
- LOAD lasts exactly 1 cycle and ignores all inputs. It goes to PLAYING if autoplay=1, else PAUSED.
- song is written on the edge that enters LOAD, so the new index is visible during the reset_player pulse.
- inc(s) = (s==NUM_SONGS-1) ? 0 : s+1. dec(s) = (s==0) ? NUM_SONGS-1 : s-1.
- PAUSED:
  - play -> PLAYING.
  - next -> song=inc(song), LOAD, autoplay=0.
  - prev -> song=dec(song), LOAD, autoplay=0.
  - song_done is ignored.
- PLAYING:
  - elapsed counter increments each cycle, saturating at PREV_WINDOW, and is cleared in LOAD.
  - play -> PAUSED; elapsed holds.
  - next -> song=inc(song), LOAD, autoplay=1.
  - prev -> if elapsed < PREV_WINDOW then song=dec(song), else song unchanged (restart); LOAD, autoplay=1.
  - song_done -> compute pending (below).
    - Repeat-off with song==NUM_SONGS-1: song=0, LOAD, autoplay=0 (end of playlist, no gap).
    - Otherwise, GAP_CYCLES>0: GAP with counter=GAP_CYCLES-1.
    - Otherwise, GAP_CYCLES==0: song=pending, LOAD, autoplay=1.
- Pending index on song_done:
  - off / all: inc(song).
  - one: song.
  - shuffle: c = LFSR[SONG_W-1:0]; if c >= NUM_SONGS then c -= NUM_SONGS; if c == song then c = inc(song). The result is never equal to the current song.
- GAP: play=0, pending is held, song is unchanged. The counter decrements each cycle.
  - counter==0 -> song=pending, LOAD, autoplay=1.
  - play -> song=pending, LOAD, autoplay=0.
  - next -> song=inc(song), LOAD, autoplay=1.
  - prev -> song=dec(song), LOAD, autoplay=1.
  - song_done is ignored.
- Manual next/prev is always sequential (wraps) in every mode, including repeat-one and shuffle.
- mode is sampled only when pending is computed; a mode change mid-GAP does not alter pending.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle including LOAD; never all-zero.
- Reset mid-GAP or mid-PLAYING aborts immediately to the reset values.

Decomposition:
- Package playlist_pkg holds:
  - state encodings LOAD=2'd0, PAUSED=2'd1, PLAYING=2'd2, GAP=2'd3;
  - mode encodings MODE_OFF/ALL/ONE/SHUF;
  - the LFSR seed and tap mask.
- One sub-module: shuffle_lfsr (8-bit, clk, active-low sync reset, free-running, output q[7:0]).
- Counters and next-index logic stay in playlist_ctrl.

Test Plan:
- Reset low 3 cycles, then high -> during reset song=0, play=0, reset_player=1, state=LOAD; cycle 1 after release state=PAUSED, reset_player=0; play pulse -> play=1 next cycle.
- PLAYING song=1, mode=01, GAP_CYCLES=4, song_done pulse -> state=GAP for exactly 4 cycles with play=0; then LOAD with song=2, reset_player=1 for 1 cycle; then PLAYING.
- mode=00, PLAYING song=3, song_done -> no GAP; LOAD with song=0, then PAUSED, play=0.
- PREV_WINDOW=8: PLAYING song=2, prev after 3 cycles -> song=1, PLAYING after LOAD; prev after 20 cycles -> song stays 2, reset_player pulses, PLAYING.
- play_button and next_button in the same cycle while PLAYING song=0 -> PAUSED, song=0, no reset_player; next alone in PAUSED song=3 -> song=0, LOAD, PAUSED.
- mode=11, 200 song_done events with GAP_CYCLES=0 -> pending never equals the prior song, every index 0..3 appears, reset_player is 1 exactly once per event; a reset pulse mid-sequence returns song=0, LFSR=8'h01.
